// File: rtl/c_bank_loader.sv
// c_bank_loader: write-side sequencer for the FFT stage coefficient bank.
// Walks twiddle indices 1..N/2-1, reads cos/sin from a registered ROM and
// issues one bank write per index carrying cos, cos+sin and cos-sin.
// Index 0 is never written because the bank hardwires it to 1.0.
// Optional feature macro: C_BANK_LOADER_CONJ_EN (adds 'inv' for conjugate
// twiddles, which swaps the cos+sin / cos-sin outputs).
module c_bank_loader #(
    parameter int N   = 16,
    parameter int MSB = 8,
    localparam int AW = (N / 2 > 1) ? $clog2(N / 2) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef C_BANK_LOADER_CONJ_EN
    input  logic             inv,
`endif
    output logic [AW-1:0]    rom_addr,
    input  logic [MSB-1:0]   rom_cos,
    input  logic [MSB-1:0]   rom_sin,
    output logic             we,
    output logic [AW-1:0]    addr,
    output logic [MSB-1:0]   c_out,
    output logic [MSB:0]     cps_out,
    output logic [MSB:0]     cms_out,
    output logic             busy,
    output logic             done
);

    // With a single-entry bank there is nothing to load.
    localparam bit          DEGEN  = (N / 2 <= 1);
    localparam logic [AW-1:0] K_LAST = AW'(N / 2 - 1);
    localparam logic [AW-1:0] K_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   k;
    logic [MSB:0]    cos_x, sin_x;
    logic [MSB:0]    sum_x, dif_x;
    logic [MSB:0]    cps_nx, cms_nx;

`ifdef C_BANK_LOADER_CONJ_EN
    logic            inv_q;
`endif

    // Sign-extend to MSB+1 bits; the sum/difference can never overflow there.
    always_comb begin
        cos_x  = {rom_cos[MSB-1], rom_cos};
        sin_x  = {rom_sin[MSB-1], rom_sin};
        sum_x  = cos_x + sin_x;
        dif_x  = cos_x - sin_x;
        cps_nx = sum_x;
        cms_nx = dif_x;
`ifdef C_BANK_LOADER_CONJ_EN
        // Negating sin just exchanges the two terms.
        if (inv_q) begin
            cps_nx = dif_x;
            cms_nx = sum_x;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: three cycles per index (fetch, latch, write).
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = DEGEN ? S_DONE : S_FETCH;
            S_FETCH: state_nx = S_LATCH;
            S_LATCH: state_nx = S_WRITE;
            S_WRITE: state_nx = (k == K_LAST) ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered datapath and outputs. rom_addr is loaded on entry to FETCH
    // so the registered ROM returns data during LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= K_ONE;
            rom_addr <= '0;
            we       <= 1'b0;
            addr     <= '0;
            c_out    <= '0;
            cps_out  <= '0;
            cms_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef C_BANK_LOADER_CONJ_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k        <= K_ONE;
                        rom_addr <= K_ONE;
`ifdef C_BANK_LOADER_CONJ_EN
                        inv_q    <= inv;
`endif
                        if (DEGEN) done <= 1'b1;
                        else       busy <= 1'b1;
                    end
                end
                S_LATCH: begin
                    c_out   <= rom_cos;
                    cps_out <= cps_nx;
                    cms_out <= cms_nx;
                    addr    <= k;
                    we      <= 1'b1;
                end
                S_WRITE: begin
                    if (k == K_LAST) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        k        <= k + K_ONE;
                        rom_addr <= k + K_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
